// File: rtl/sat_pkg.sv
// Shared SAT-engine types: variable index width, implication record and the
// propagation state encoding used by the arbiter and the conflict detector.
package sat_pkg;

    localparam int VAR_W = 9;

    typedef struct packed {
        logic [VAR_W-1:0] var_idx;
        logic             val;
    } implication_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } sat_state_t;

endpackage

// File: rtl/imply_fifo.sv
// Per-requester implication queue with a combinational head so an entry can be
// issued the cycle after it is pushed. Flush and reset empty the queue at once.
module imply_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;

    always_ff @(posedge clock) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Data storage carries no reset; validity is tracked purely by the pointers.
    always_ff @(posedge clock) begin
        if (w_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/imply_arbiter.sv
// Round-robin arbiter feeding queued implications to the conflict detector one
// per cycle; a detected conflict flushes every queue and halts until resume.
module imply_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int FIFO_DEPTH = 2,
    parameter  int VAR_W      = sat_pkg::VAR_W,
    localparam int SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*VAR_W-1:0] req_var_idx,
    input  logic [NUM_REQ-1:0]       req_val,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     det_en,
    output logic [VAR_W-1:0]         det_var_idx,
    output logic                     det_val,
    input  logic                     det_conflict,
    output logic                     conflict_out,
    output logic [SRC_W-1:0]         conflict_src,
    input  logic                     resume,
    output logic                     idle
);
    import sat_pkg::*;

    sat_state_t       r_state;
    logic [SRC_W-1:0] r_rr_ptr;
    logic [SRC_W-1:0] r_conflict_src;

    logic             w_run;
    logic             w_conflict;
    logic             w_grant_found;
    logic [SRC_W-1:0] w_grant_idx;
    logic [SRC_W-1:0] w_rr_next;
    logic [SRC_W:0]   w_cand;
    logic [VAR_W:0]   w_sel;
    logic [NUM_REQ-1:0] w_empty;
    logic [NUM_REQ-1:0] w_full;
    logic [NUM_REQ-1:0] w_push;
    logic [NUM_REQ-1:0] w_pop;
    logic [VAR_W:0]   w_head [NUM_REQ];

    assign w_run = (r_state == ST_RUN);

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_ready[gi] = w_run && !w_full[gi];
            assign w_push[gi]    = req_valid[gi] && req_ready[gi];
            assign w_pop[gi]     = det_en && (w_grant_idx == SRC_W'(gi));

            imply_fifo #(
                .DEPTH (FIFO_DEPTH),
                .WIDTH (VAR_W + 1)
            ) u_fifo (
                .clock   (clock),
                .reset   (reset),
                .i_push  (w_push[gi]),
                .i_pop   (w_pop[gi]),
                .i_flush (w_conflict),
                .i_data  ({req_var_idx[gi*VAR_W +: VAR_W], req_val[gi]}),
                .o_full  (w_full[gi]),
                .o_empty (w_empty[gi]),
                .o_head  (w_head[gi])
            );
        end
    endgenerate

    // Scan from rr_ptr upward (wrapping) and take the first non-empty queue.
    always_comb begin
        w_grant_found = 1'b0;
        w_grant_idx   = '0;
        w_cand        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, r_rr_ptr} + (SRC_W+1)'(k);
            if (w_cand >= (SRC_W+1)'(NUM_REQ))
                w_cand = w_cand - (SRC_W+1)'(NUM_REQ);
            if (!w_grant_found && !w_empty[w_cand[SRC_W-1:0]]) begin
                w_grant_found = 1'b1;
                w_grant_idx   = w_cand[SRC_W-1:0];
            end
        end
    end

    assign w_rr_next   = (w_grant_idx == SRC_W'(NUM_REQ-1)) ? '0 : w_grant_idx + 1'b1;
    assign w_sel       = w_head[w_grant_idx];
    assign det_en      = w_run && w_grant_found;
    assign det_var_idx = det_en ? w_sel[VAR_W:1] : '0;
    assign det_val     = det_en ? w_sel[0] : 1'b0;
    assign w_conflict  = det_en && det_conflict;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_RUN;
            r_rr_ptr       <= '0;
            r_conflict_src <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (det_en)
                        r_rr_ptr <= w_rr_next;
                    if (w_conflict) begin
                        r_state        <= ST_HALT;
                        r_conflict_src <= w_grant_idx;
                    end
                end
                ST_HALT: begin
                    if (resume)
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign conflict_out = (r_state == ST_HALT);
    assign conflict_src = r_conflict_src;
    assign idle         = w_run && (&w_empty);

endmodule

// File: tb/tb_imply_arbiter.sv
// Randomized and directed bench for imply_arbiter against a queue-based model
// of the requester FIFOs, round-robin pointer and RUN/HALT behaviour.
module tb_imply_arbiter;
    localparam int NREQ  = 4;
    localparam int DEPTH = 2;
    localparam int VW    = 9;

    logic                 clock;
    logic                 reset;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*VW-1:0]   req_var_idx;
    logic [NREQ-1:0]      req_val;
    logic [NREQ-1:0]      req_ready;
    logic                 det_en;
    logic [VW-1:0]        det_var_idx;
    logic                 det_val;
    logic                 det_conflict;
    logic                 conflict_out;
    logic [1:0]           conflict_src;
    logic                 resume;
    logic                 idle;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int mq [NREQ][$];
    bit m_run   = 1'b1;
    int m_rr    = 0;
    int m_src   = 0;
    bit m_valid = 1'b0;
    int d_seen [$];

    imply_arbiter #(.NUM_REQ(NREQ), .FIFO_DEPTH(DEPTH), .VAR_W(VW)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_var_idx  (req_var_idx),
        .req_val      (req_val),
        .req_ready    (req_ready),
        .det_en       (det_en),
        .det_var_idx  (det_var_idx),
        .det_val      (det_val),
        .det_conflict (det_conflict),
        .conflict_out (conflict_out),
        .conflict_src (conflict_src),
        .resume       (resume),
        .idle         (idle)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock cycle: drive inputs, check outputs at the falling edge, advance model at the rising edge.
    // conf_req >= 0 raises det_conflict when that requester is granted.
    task automatic step(input logic [NREQ-1:0] v, input logic [NREQ*VW-1:0] vars,
                        input logic [NREQ-1:0] vals, input int conf_req,
                        input logic res, input logic rst);
        int g;
        int hd;
        int e_var;
        logic e_en, e_val, e_idle, conf;
        logic [NREQ-1:0] e_rdy;
        g = -1;
        if (m_run)
            for (int k = 0; k < NREQ; k++)
                if (g < 0 && mq[(m_rr + k) % NREQ].size() > 0) g = (m_rr + k) % NREQ;
        e_en  = (g >= 0);
        e_var = 0;
        e_val = 1'b0;
        if (e_en) begin
            hd    = mq[g][0];
            e_var = hd >> 1;
            e_val = hd[0];
        end
        e_idle = m_run;
        for (int i = 0; i < NREQ; i++) begin
            e_rdy[i] = m_run && (mq[i].size() < DEPTH);
            if (mq[i].size() != 0) e_idle = 1'b0;
        end
        conf = (conf_req >= 0) && (g == conf_req);

        req_valid    = v;
        req_var_idx  = vars;
        req_val      = vals;
        det_conflict = conf;
        resume       = res;
        reset        = rst;

        @(negedge clock);
        if (m_valid) begin
            n_tests++;
            if (det_en !== e_en) begin n_fail++; $display("FAIL det_en: got %b expected %b", det_en, e_en); end
            n_tests++;
            if (det_var_idx !== VW'(e_var)) begin n_fail++; $display("FAIL det_var_idx: got %0d expected %0d", det_var_idx, e_var); end
            n_tests++;
            if (det_val !== e_val) begin n_fail++; $display("FAIL det_val: got %b expected %b", det_val, e_val); end
            n_tests++;
            if (req_ready !== e_rdy) begin n_fail++; $display("FAIL req_ready: got %b expected %b", req_ready, e_rdy); end
            n_tests++;
            if (conflict_out !== !m_run) begin n_fail++; $display("FAIL conflict_out: got %b expected %b", conflict_out, !m_run); end
            n_tests++;
            if (conflict_src !== 2'(m_src)) begin n_fail++; $display("FAIL conflict_src: got %0d expected %0d", conflict_src, m_src); end
            n_tests++;
            if (idle !== e_idle) begin n_fail++; $display("FAIL idle: got %b expected %b", idle, e_idle); end
        end
        if (det_en === 1'b1) begin
            d_seen.push_back(int'(det_var_idx));
            $display("[TB] issue var=%0d val=%b conflict=%b", det_var_idx, det_val, det_conflict);
        end

        if (rst) begin
            for (int i = 0; i < NREQ; i++) mq[i].delete();
            m_run = 1'b1; m_rr = 0; m_src = 0; m_valid = 1'b1;
        end else if (m_run) begin
            if (conf) begin
                for (int i = 0; i < NREQ; i++) mq[i].delete();
                m_run = 1'b0; m_src = g; m_rr = (g + 1) % NREQ;
            end else begin
                if (e_en) begin
                    void'(mq[g].pop_front());
                    m_rr = (g + 1) % NREQ;
                end
                for (int i = 0; i < NREQ; i++)
                    if (v[i] && e_rdy[i]) mq[i].push_back(int'(vars[i*VW +: VW]) * 2 + int'(vals[i]));
            end
        end else if (res) begin
            m_run = 1'b1;
        end

        @(posedge clock);
        #1;
    endtask

    task automatic quiet(input int n);
        for (int c = 0; c < n; c++) step('0, '0, '0, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        step('0, '0, '0, -1, 1'b0, 1'b1);
        step('0, '0, '0, -1, 1'b0, 1'b1);
        quiet(4);
        n_tests++;
        if (req_ready !== 4'b1111 || idle !== 1'b1 || det_en !== 1'b0) begin
            n_fail++; $display("FAIL reset_idle: got ready=%b idle=%b det_en=%b expected 1111 1 0", req_ready, idle, det_en);
        end
    endtask

    task automatic test_fairness();
        logic [NREQ*VW-1:0] vv;
        for (int i = 0; i < NREQ; i++) vv[i*VW +: VW] = VW'(i + 1);
        d_seen.delete();
        step(4'b1111, vv, 4'b1111, -1, 1'b0, 1'b0);
        quiet(5);
        n_tests++;
        if (d_seen.size() != 4 || d_seen[0] != 1 || d_seen[1] != 2 || d_seen[2] != 3 || d_seen[3] != 4) begin
            n_fail++; $display("FAIL fairness_order: got %p expected '{1,2,3,4}", d_seen);
        end
        n_tests++;
        if (idle !== 1'b1) begin n_fail++; $display("FAIL fairness_idle: got %b expected 1", idle); end
    endtask

    task automatic test_backpressure();
        logic [NREQ*VW-1:0] vv;
        logic [NREQ-1:0] v;
        int sent;
        int r0 [$];
        bit saw_block;
        sent = 0; saw_block = 1'b0;
        d_seen.delete();
        for (int c = 0; c < 30 && sent < 3; c++) begin
            v = (c < 6) ? 4'b1110 : 4'b0000;
            if (sent < 3) v[0] = 1'b1;
            for (int i = 1; i < NREQ; i++) vv[i*VW +: VW] = VW'(100 + c);
            vv[0 +: VW] = VW'(10 + sent);
            if (m_run && mq[0].size() < DEPTH) sent++;
            step(v, vv, '1, -1, 1'b0, 1'b0);
            if (req_ready[0] === 1'b0) saw_block = 1'b1;
        end
        quiet(12);
        foreach (d_seen[k]) if (d_seen[k] >= 10 && d_seen[k] <= 12) r0.push_back(d_seen[k]);
        n_tests++;
        if (r0.size() != 3 || r0[0] != 10 || r0[1] != 11 || r0[2] != 12) begin
            n_fail++; $display("FAIL backpressure_r0: got %p expected '{10,11,12}", r0);
        end
        n_tests++;
        if (!saw_block) begin n_fail++; $display("FAIL backpressure_block: got ready[0] never low expected low once"); end
    endtask

    task automatic test_conflict();
        logic [NREQ*VW-1:0] vv;
        for (int i = 0; i < NREQ; i++) vv[i*VW +: VW] = VW'(5 + i);
        d_seen.delete();
        step(4'b1111, vv, 4'b1111, 2, 1'b0, 1'b0);
        for (int c = 0; c < 10 && m_run; c++) step('0, '0, '0, 2, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) step(4'b1111, vv, 4'b1111, 2, 1'b0, 1'b0);
        n_tests++;
        if (d_seen.size() == 0 || d_seen[d_seen.size()-1] != 7) begin
            n_fail++; $display("FAIL conflict_last: got %p expected last 7", d_seen);
        end
        n_tests++;
        if (conflict_out !== 1'b1 || conflict_src !== 2'd2 || req_ready !== 4'b0000 || det_en !== 1'b0) begin
            n_fail++; $display("FAIL conflict_hold: got out=%b src=%0d ready=%b det_en=%b expected 1 2 0000 0",
                               conflict_out, conflict_src, req_ready, det_en);
        end
    endtask

    task automatic test_resume();
        logic [NREQ*VW-1:0] vv;
        vv = '0;
        vv[1*VW +: VW] = VW'(9);
        step('0, '0, '0, -1, 1'b1, 1'b0);
        n_tests++;
        if (conflict_out !== 1'b0 || idle !== 1'b1) begin
            n_fail++; $display("FAIL resume_state: got out=%b idle=%b expected 0 1", conflict_out, idle);
        end
        d_seen.delete();
        step(4'b0010, vv, 4'b0010, -1, 1'b0, 1'b0);
        step('0, '0, '0, -1, 1'b1, 1'b0);
        n_tests++;
        if (d_seen.size() != 1 || d_seen[0] != 9) begin
            n_fail++; $display("FAIL resume_issue: got %p expected '{9}", d_seen);
        end
    endtask

    task automatic test_reset_mid();
        logic [NREQ*VW-1:0] vv;
        for (int i = 0; i < NREQ; i++) vv[i*VW +: VW] = VW'(20 + i);
        step(4'b1111, vv, '0, -1, 1'b0, 1'b0);
        step(4'b1111, vv, '0, -1, 1'b0, 1'b0);
        step('0, '0, '0, -1, 1'b0, 1'b1);
        d_seen.delete();
        quiet(3);
        n_tests++;
        if (d_seen.size() != 0) begin n_fail++; $display("FAIL reset_mid_flush: got %0d issues expected 0", d_seen.size()); end
        for (int i = 0; i < NREQ; i++) vv[i*VW +: VW] = VW'(30 + i);
        step(4'b1111, vv, '0, -1, 1'b0, 1'b0);
        quiet(2);
        n_tests++;
        if (d_seen.size() == 0 || d_seen[0] != 30) begin
            n_fail++; $display("FAIL reset_mid_rr: got %p expected first 30", d_seen);
        end
    endtask

    task automatic test_random();
        logic [NREQ*VW-1:0] vv;
        logic [NREQ-1:0] v, b;
        int cr;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) vv[i*VW +: VW] = VW'($urandom_range(0, 511));
            v  = NREQ'($urandom_range(0, 15));
            b  = NREQ'($urandom_range(0, 15));
            cr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1;
            step(v, vv, b, cr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end
        quiet(10);
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_var_idx = '0; req_val = '0;
        det_conflict = 1'b0; resume = 1'b0;
        @(posedge clock);
        #1;
        test_reset();
        test_fairness();
        test_backpressure();
        test_conflict();
        test_resume();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imply_arbiter.md
IMPLY_ARBITER -- requirements
Module: imply_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of clause-evaluator requesters.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 2, giving queue entries per requester (power of two).
REQ-003 The module SHALL have parameter VAR_W, default 9, giving the variable index width (512 variables).
REQ-004 The module SHALL have port clock, input, 1, the rising-edge clock.
REQ-005 The module SHALL have port reset, input, 1, the synchronous active-high reset.
REQ-006 The module SHALL have port req_valid, input, NUM_REQ, meaning requester i offers an implication.
REQ-007 The module SHALL have port req_var_idx, input, NUM_REQ*VAR_W, giving the implied variable per requester (slice i).
REQ-008 The module SHALL have port req_val, input, NUM_REQ, giving the implied value per requester.
REQ-009 The module SHALL have port req_ready, output, NUM_REQ, meaning requester i may push this cycle.
REQ-010 The module SHALL have port det_en, output, 1, the conflict detector enable.
REQ-011 The module SHALL have port det_var_idx, output, VAR_W, the variable sent to the detector.
REQ-012 The module SHALL have port det_val, output, 1, the value sent to the detector.
REQ-013 The module SHALL have port det_conflict, input, 1, the detector's same-cycle conflict flag.
REQ-014 The module SHALL have port conflict_out, output, 1, meaning a conflict is held for the solver.
REQ-015 The module SHALL have port conflict_src, output, log2(NUM_REQ), the requester whose implication conflicted.
REQ-016 The module SHALL have port resume, input, 1, the solver's acknowledgement of a conflict.
REQ-017 The module SHALL have port idle, output, 1, meaning propagation is quiescent (all queues empty, RUN state).

Function
REQ-018 Push: on a cycle with req_valid[i] && req_ready[i], the entry {var_idx, val} SHALL be written to FIFO i, available at its head the next cycle.
REQ-019 req_ready[i] SHALL be 1 only in RUN with FIFO i not full; a same-cycle pop SHALL NOT make a full FIFO ready.
REQ-020 Issue: in RUN, among non-empty FIFOs, the arbiter SHALL grant one per cycle by round-robin starting at rr_ptr, driving det_en=1 and det_var_idx/det_val combinationally from that head, and popping it at the edge.
REQ-021 After a grant to i, rr_ptr SHALL become (i+1) mod NUM_REQ; with no grant, rr_ptr SHALL hold.
REQ-022 det_en SHALL be 0 when all FIFOs are empty or state is HALT; det_var_idx/det_val SHALL then be 0.
REQ-023 FSM states SHALL be RUN and HALT; RUN->HALT when det_en && det_conflict; HALT->RUN when resume; otherwise hold.
REQ-024 On the RUN->HALT edge, every FIFO SHALL be emptied (the conflicting entry included) and conflict_src SHALL capture the granted index.
REQ-025 In HALT, conflict_out SHALL be 1, req_ready SHALL be all 0, det_en SHALL be 0, and req_valid SHALL be ignored.
REQ-026 Pushes arriving in the conflict cycle SHALL be discarded, since the flush wins over the push.
REQ-027 conflict_src SHALL hold its value until the next conflict.
REQ-028 resume in RUN SHALL have no effect.
REQ-029 idle SHALL equal (state==RUN) && all FIFOs empty, registered-state based only.
REQ-030 Throughput SHALL be one implication per cycle, with 1-cycle latency from push to earliest issue.

Reset
REQ-031 While reset is high at the clock edge: state=RUN, all FIFO pointers/counts=0, rr_ptr=0, conflict_src=0.
REQ-032 After reset: det_en=0, det_var_idx=0, det_val=0, conflict_out=0, idle=1, req_ready all 1.
REQ-033 Reset mid-operation (including in HALT) SHALL discard all queued entries without issuing them.

Structure
REQ-034 VAR_W, the implication struct {var_idx, val} and the RUN/HALT enum SHALL live in the shared package sat_pkg, also used by the conflict detector.
REQ-035 The per-requester queue SHALL be one sub-module, imply_fifo (push, pop, flush, full, empty, head), instantiated NUM_REQ times.

Verification
REQ-036 Reset then idle: no requests -> idle=1, det_en=0, req_ready=4'b1111 every cycle.
REQ-037 Fairness: all four requesters push once in the same cycle (var 1..4, val 1) with det_conflict=0 -> detector sees vars 1,2,3,4 on four consecutive cycles, then idle=1.
REQ-038 Backpressure: requester 0 pushes three entries back-to-back -> req_ready[0]=0 after the second push until the first pops; no entry lost or duplicated.
REQ-039 Conflict: issue var 7 from requester 2 with det_conflict=1 -> next cycle conflict_out=1, conflict_src=2, all FIFOs empty, req_ready=0; pending entries never reach the detector.
REQ-040 Resume: in HALT, assert resume for 1 cycle -> next cycle conflict_out=0 and idle=1; a new push of var 9 issues one cycle later.
REQ-041 Reset mid-flight: FIFOs holding 3 entries, assert reset -> no det_en afterwards, rr_ptr=0 (requester 0 wins the next tie).
